// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR checker: the run-control FSM encoding
// and the generator for the default feedback-tap mask.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  localparam int MAX_WIDTH = 1024;

  // Even bit positions 0..248 set, clipped to the register width.
  function automatic logic [MAX_WIDTH-1:0] even_tap_mask(input int width);
    logic [MAX_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i <= 248; i += 2) begin
      if (i < width) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single-step of the Fibonacci LFSR, forward (dir=0) or the
// exact inverse step (dir=1, meaningful only when TAP_MASK[0] is set).
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 256,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(even_tap_mask(WIDTH))
) (
  input  logic [WIDTH-1:0] state,
  input  logic             dir,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH-1:0] REV_MASK = {TAP_MASK[WIDTH-1:1], 1'b0};

  logic fwd_fb;
  logic rev_fb;

  assign fwd_fb = ^(state & TAP_MASK);
  // The bit shifted out going forward is recovered from the new MSB and the
  // remaining taps, which is why tap 0 must be present for reversal.
  assign rev_fb = state[WIDTH-1] ^ (^({state[WIDTH-2:0], 1'b0} & REV_MASK));

  assign next = dir ? {state[WIDTH-2:0], rev_fb} : {fwd_fb, state[WIDTH-1:1]};

endmodule

// File: rtl/lfsr_checker.sv
// Steps an LFSR from a seed until it equals a target or a step budget runs out.
// Optional backward stepping is compiled in with LFSR_CHECKER_REVERSE_EN.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 256,
  parameter logic [WIDTH-1:0] TAP_MASK  = WIDTH'(even_tap_mask(WIDTH)),
  parameter int               MAX_STEPS = 128000,
  localparam int              STEP_W    = $clog2(MAX_STEPS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  seed,
  input  logic [WIDTH-1:0]  target,
  input  logic              start,
  input  logic              abort,
  input  logic              ack,
`ifdef LFSR_CHECKER_REVERSE_EN
  input  logic              reverse,
`endif
  output logic              busy,
  output logic              done,
  output logic              win,
  output logic [STEP_W-1:0] steps
);

  fsm_state_t        state_q, state_d;
  logic [WIDTH-1:0]  lfsr_q;
  logic [WIDTH-1:0]  target_q;
  logic [WIDTH-1:0]  lfsr_next;
  logic [STEP_W-1:0] steps_q;
  logic              dir_q;
  logic              dir_sel;
  logic              win_q;
  logic              hit;
  logic              budget_out;

`ifdef LFSR_CHECKER_REVERSE_EN
  if (TAP_MASK[0] == 1'b0) begin : g_tap0_check
    $error("lfsr_checker: reverse stepping requires TAP_MASK[0] = 1");
  end
  assign dir_sel = reverse;
`else
  assign dir_sel = 1'b0;
`endif

  lfsr_step #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAP_MASK)
  ) u_step (
    .state (lfsr_q),
    .dir   (dir_q),
    .next  (lfsr_next)
  );

  assign hit        = (lfsr_q == target_q);
  assign budget_out = (steps_q == STEP_W'(MAX_STEPS));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort)                   state_d = IDLE;
        else if (hit || budget_out)  state_d = DONE;
      end
      DONE:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q   <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
      win_q    <= 1'b0;
      steps_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            lfsr_q   <= seed;
            target_q <= target;
            dir_q    <= dir_sel;
            win_q    <= 1'b0;
            steps_q  <= '0;
          end
        end
        RUN: begin
          // Match wins over budget exhaustion; abort freezes everything.
          if (!abort) begin
            if (hit) begin
              win_q <= 1'b1;
            end else if (budget_out) begin
              win_q <= 1'b0;
            end else begin
              lfsr_q  <= lfsr_next;
              steps_q <= steps_q + STEP_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign win   = win_q;
  assign steps = steps_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: an 8-bit rotate configuration with a
// small budget, plus the default 256-bit configuration.
module tb_lfsr_checker;

  localparam int         W8    = 8;
  localparam logic [7:0] TAP8  = 8'h01;
  localparam int         MAX8  = 20;
  localparam int         SW8   = $clog2(MAX8 + 1);
  localparam int         W     = 256;
  localparam int         SW    = $clog2(128000 + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]     s8_seed, s8_target;
  logic           s8_start, s8_abort, s8_ack;
  logic           s8_busy, s8_done, s8_win;
  logic [SW8-1:0] s8_steps;

  logic [W-1:0]   b_seed, b_target;
  logic           b_start, b_abort, b_ack;
  logic           b_busy, b_done, b_win;
  logic [SW-1:0]  b_steps;

`ifdef LFSR_CHECKER_REVERSE_EN
  logic s8_reverse, b_reverse;
`endif

  lfsr_checker #(.WIDTH(W8), .TAP_MASK(TAP8), .MAX_STEPS(MAX8)) u8 (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (s8_seed),
    .target  (s8_target),
    .start   (s8_start),
    .abort   (s8_abort),
    .ack     (s8_ack),
`ifdef LFSR_CHECKER_REVERSE_EN
    .reverse (s8_reverse),
`endif
    .busy    (s8_busy),
    .done    (s8_done),
    .win     (s8_win),
    .steps   (s8_steps)
  );

  lfsr_checker u256 (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (b_seed),
    .target  (b_target),
    .start   (b_start),
    .abort   (b_abort),
    .ack     (b_ack),
`ifdef LFSR_CHECKER_REVERSE_EN
    .reverse (b_reverse),
`endif
    .busy    (b_busy),
    .done    (b_done),
    .win     (b_win),
    .steps   (b_steps)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: parity of tapped bits enters at the top, everything
  // else moves one place toward bit 0.
  function automatic logic [255:0] model_step(input logic [255:0] s, input logic [255:0] mask,
                                               input int w);
    logic [255:0] n;
    n = s >> 1;
    n[w-1] = ($countones(s & mask) % 2) == 1;
    return n;
  endfunction

  function automatic logic [255:0] default_mask();
    logic [255:0] m;
    m = '0;
    for (int i = 0; i <= 248; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  // First match within the budget, otherwise a miss after exactly max steps.
  task automatic model_run(input logic [255:0] sd, input logic [255:0] tg, input logic [255:0] mask,
                           input int w, input int max, output bit mwin, output int msteps);
    logic [255:0] s;
    s = sd;
    msteps = 0;
    mwin = 1'b0;
    while (1) begin
      if (s == tg) begin mwin = 1'b1; break; end
      if (msteps == max) break;
      s = model_step(s, mask, w);
      msteps++;
    end
  endtask

  // Launches one run on the 8-bit instance; lat = edges from the start edge to done.
  task automatic run8(input logic [7:0] sd, input logic [7:0] tg, output int lat);
    s8_seed   = sd;
    s8_target = tg;
    s8_start  = 1'b1;
    @(posedge clk); #1;
    s8_start  = 1'b0;
    s8_seed   = 8'($urandom);
    s8_target = 8'($urandom);
    lat = 0;
    while (s8_done !== 1'b1 && lat < 64) begin
      s8_start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    s8_start = 1'b0;
  endtask

  task automatic ack8();
    s8_ack = 1'b1;
    @(posedge clk); #1;
    s8_ack = 1'b0;
  endtask

  initial begin
    int           lat;
    bit           mwin;
    int           msteps;
    bit           seen;
    logic [255:0] s;
    logic [255:0] t;
    logic [7:0]   sd;
    logic [7:0]   tg;

    s8_seed = '0; s8_target = '0; s8_start = 0; s8_abort = 0; s8_ack = 0;
    b_seed  = '0; b_target  = '0; b_start  = 0; b_abort  = 0; b_ack  = 0;
`ifdef LFSR_CHECKER_REVERSE_EN
    s8_reverse = 1'b0;
    b_reverse  = 1'b0;
`endif

    #1;
    check("rst8_busy", s8_busy, 0);
    check("rst8_done", s8_done, 0);
    check("rst8_win", s8_win, 0);
    check("rst8_steps", s8_steps, 0);
    check("rst256_busy", b_busy, 0);
    check("rst256_done", b_done, 0);
    check("rst256_win", b_win, 0);
    check("rst256_steps", b_steps, 0);
    #21 reset_n = 1'b1;
    @(posedge clk); #1;

    run8(8'h01, 8'h80, lat);
    check("one_step_win", s8_win, 1);
    check("one_step_steps", s8_steps, 1);
    check("one_step_latency", lat, 2);
    ack8();
    check("one_step_ack_done", s8_done, 0);

    run8(8'h01, 8'h02, lat);
    check("seven_step_win", s8_win, 1);
    check("seven_step_steps", s8_steps, 7);
    check("seven_step_latency", lat, 8);
    ack8();

    run8(8'h01, 8'h00, lat);
    check("budget_win", s8_win, 0);
    check("budget_steps", s8_steps, MAX8);
    check("budget_latency", lat, MAX8 + 1);
    s8_abort = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s8_abort = 1'b0;
    check("hold_done", s8_done, 1);
    check("hold_steps", s8_steps, MAX8);
    check("hold_win", s8_win, 0);
    s8_start = 1'b1;
    s8_ack   = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    s8_ack   = 1'b0;
    check("ack_start_done", s8_done, 0);
    check("ack_start_busy", s8_busy, 0);
    @(posedge clk); #1;
    check("ack_start_ignored", s8_busy, 0);

    for (int i = 0; i < 10; i++) begin
      sd = 8'($urandom);
      t  = {248'd0, sd};
      repeat ($urandom_range(0, 24)) t = model_step(t, {248'd0, TAP8}, W8);
      tg = t[7:0];
      if ($urandom_range(0, 3) == 0) tg = 8'($urandom);
      model_run({248'd0, sd}, {248'd0, tg}, {248'd0, TAP8}, W8, MAX8, mwin, msteps);
      run8(sd, tg, lat);
      check("rand_win", s8_win, mwin);
      check("rand_steps", s8_steps, msteps);
      check("rand_latency", lat, msteps + 1);
      ack8();
    end

    s8_seed = 8'h01; s8_target = 8'h00; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_busy", s8_busy, 1);
    s8_abort = 1'b1;
    @(posedge clk); #1;
    s8_abort = 1'b0;
    check("abort_busy", s8_busy, 0);
    check("abort_done", s8_done, 0);
    s8_seed = 8'h5a; s8_target = 8'h5a; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    s8_abort = 1'b1;
    @(posedge clk); #1;
    s8_abort = 1'b0;
    check("abort_prio_busy", s8_busy, 0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (s8_done) seen = 1'b1;
    end
    check("abort_never_done", seen, 0);

`ifdef LFSR_CHECKER_REVERSE_EN
    s8_reverse = 1'b1;
    run8(8'h80, 8'h01, lat);
    s8_reverse = 1'b0;
    check("rev_win", s8_win, 1);
    check("rev_steps", s8_steps, 1);
    ack8();
    run8(8'h01, 8'h80, lat);
    check("rev_then_fwd_win", s8_win, 1);
    check("rev_then_fwd_steps", s8_steps, 1);
    ack8();
`endif

    for (int k = 0; k < 8; k++) s[k*32 +: 32] = $urandom;
    t = s;
    repeat (1000) t = model_step(t, default_mask(), W);
    model_run(s, t, default_mask(), W, 128000, mwin, msteps);
    b_seed = s; b_target = t; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    b_seed  = '0;
    lat = 0;
    while (b_done !== 1'b1 && lat < 1100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w256_win", b_win, 1);
    check("w256_steps", b_steps, 1000);
    check("w256_model_steps", b_steps, msteps);
    check("w256_latency", lat, 1001);
    b_ack = 1'b1;
    @(posedge clk); #1;
    b_ack = 1'b0;

    s8_seed = 8'h01; s8_target = 8'h00; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", s8_busy, 0);
    check("midrst_done", s8_done, 0);
    check("midrst_win", s8_win, 0);
    check("midrst_steps", s8_steps, 0);
    #2 reset_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (s8_busy || s8_done) seen = 1'b1;
    end
    check("midrst_stays_idle", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 256: state/seed/target width in bits, legal range 8..1024.
REQ-002 SHALL have parameter TAP_MASK, default all even bit positions 0..248 set and all other bits clear: feedback taps.
REQ-003 SHALL have parameter MAX_STEPS, default 128000: step budget per run.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port seed, input, WIDTH bits: initial state, sampled at start.
REQ-007 SHALL have port target, input, WIDTH bits: comparison value, sampled at start.
REQ-008 SHALL have port start, input, 1 bit: request a run; honoured only in IDLE.
REQ-009 SHALL have port abort, input, 1 bit: cancel a run in progress.
REQ-010 SHALL have port ack, input, 1 bit: consume the result.
REQ-011 SHALL have port reverse, input, 1 bit: step direction (present only with LFSR_CHECKER_REVERSE_EN).
REQ-012 SHALL have port busy, output, 1 bit: high in RUN.
REQ-013 SHALL have port done, output, 1 bit: high in DONE.
REQ-014 SHALL have port win, output, 1 bit: match found; valid while done is high.
REQ-015 SHALL have port steps, output, $clog2(MAX_STEPS+1) bits: steps taken in the run.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL, in IDLE with start=1: load state from seed, latch target and the direction, clear steps and win, and enter RUN on the next edge.
REQ-018 SHALL compute the forward step as fb = XOR-reduce(state AND TAP_MASK), next state = {fb, state[WIDTH-1:1]}.
REQ-019 SHALL, on each RUN cycle, apply this priority:
- state==target: win<=1, enter DONE.
- else steps==MAX_STEPS: win<=0, enter DONE.
- else: step the state and increment steps by 1.
REQ-020 SHALL therefore report steps=0 and win=1 when seed equals target; a match found after N steps SHALL assert done N+1 cycles after the start edge.
REQ-021 SHALL hold done, win and steps stable in DONE until ack=1, then return to IDLE.
REQ-022 SHALL ignore start in RUN and DONE; no queuing.
REQ-023 SHALL, on abort=1 in RUN, return to IDLE on the next edge without asserting done; abort has priority over the match check in that cycle.
REQ-024 SHALL ignore abort in IDLE and DONE.
REQ-025 SHALL saturate steps at MAX_STEPS; it SHALL never wrap.
REQ-026 SHALL allow start to coincide with ack in DONE, but that start SHALL be ignored; a new run needs start in IDLE.

Reset
REQ-027 SHALL, on reset_n=0, immediately (asynchronously) force: state IDLE, busy=0, done=0, win=0, steps=0, internal state register=0.
REQ-028 SHALL, on reset mid-RUN, discard the run; after release the block SHALL idle until a new start.

Configuration
REQ-029 SHALL support macro LFSR_CHECKER_REVERSE_EN.
- Defined: the reverse port exists; a run latched with reverse=1 SHALL step backward: prev = {state[WIDTH-2:0] shifted as bits WIDTH-1:1, p0}, where p0 = state[WIDTH-1] XOR XOR-reduce({state[WIDTH-2:0],1'b0} AND TAP_MASK AND NOT 1). This exactly inverts REQ-018.
- Defined: elaboration SHALL fail if TAP_MASK[0]==0.
- Undefined: no reverse port; forward stepping only; TAP_MASK[0] is unconstrained.

Structure
REQ-030 SHALL place the FSM state enum and a default-tap-mask generator function in shared package lfsr_pkg.
REQ-031 SHALL implement next-state logic in combinational sub-module lfsr_step (parameters WIDTH and TAP_MASK; inputs state and dir; output next).

Verification
REQ-032 SHALL pass: WIDTH=8, TAP_MASK=8'h01, seed 8'h01, target 8'h80, forward -> done with win=1, steps=1.
REQ-033 SHALL pass: same configuration, target 8'h02 -> win=1, steps=7.
REQ-034 SHALL pass: same configuration, target 8'h00, MAX_STEPS=20 -> win=0, steps=20, done held until ack.
REQ-035 SHALL pass: REVERSE_EN, seed 8'h80, target 8'h01, reverse=1 -> win=1, steps=1; a forward run from that result returns 8'h80.
REQ-036 SHALL pass: abort raised 3 cycles into a run -> IDLE next cycle, done never asserted; reset_n pulsed mid-run -> all outputs 0 immediately.
REQ-037 SHALL pass: default WIDTH=256, a random seed, target = that seed stepped forward 1000 times -> win=1, steps=1000.
